// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix emulator and scanner-side helpers.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [3:0] COL0      = 4'b1110;
  localparam logic [3:0] COL1      = 4'b1101;
  localparam logic [3:0] COL2      = 4'b1011;
  localparam logic [3:0] COL3      = 4'b0111;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

endpackage

// File: rtl/scan_event_detect.sv
// Flags the first cycle the scanner strobes the last column: one pulse per full scan.
module scan_event_detect
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic       scan_evt
);

  logic [3:0] col_prev;

  // Reset to the idle pattern so a scanner already on COL3 counts as a fresh scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) col_prev <= ROWS_IDLE;
    else     col_prev <= col_in;
  end

  assign scan_evt = (col_in == COL3) && (col_prev != COL3);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates a held key on a 4x4 active-low matrix, timed in whole column scans.
// Optional contact bounce at make/break: define KEYPAD_EMU_BOUNCE_EN.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS    = 4,
  parameter int GAP_SCANS     = 2,
  parameter int CNT_W         = 8,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       busy,
  output logic       done
);

  if (HOLD_SCANS < 1 || GAP_SCANS < 1 || BOUNCE_CYCLES < 0 ||
      HOLD_SCANS >= (1 << CNT_W) || GAP_SCANS >= (1 << CNT_W)) begin : g_bad_param
    $error("keypad_matrix_emulator: illegal parameter set");
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] scan_cnt, cnt_d, cnt_inc;
  logic             pressed, pressed_d, pressed_eff;
  logic [3:0]       code_q, code_d;
  logic             scan_evt;

  scan_event_detect u_evt (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .scan_evt (scan_evt)
  );

  assign cnt_inc = (scan_cnt == '1) ? scan_cnt : scan_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      scan_cnt <= '0;
      pressed  <= 1'b0;
      code_q   <= '0;
    end else begin
      state    <= state_d;
      scan_cnt <= cnt_d;
      pressed  <= pressed_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = scan_cnt;
    pressed_d = pressed;
    code_d    = code_q;
    key_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = 1'b1;
        // A scan event coinciding with the accept is deliberately dropped.
        if (key_valid) begin
          code_d    = key_code;
          cnt_d     = '0;
          pressed_d = 1'b1;
          state_d   = PRESS;
        end
      end
      PRESS: begin
        busy = 1'b1;
        if (scan_evt) begin
          if (scan_cnt == CNT_W'(HOLD_SCANS - 1)) begin
            pressed_d = 1'b0;
            cnt_d     = '0;
            state_d   = GAP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      GAP: begin
        busy = 1'b1;
        if (scan_evt) begin
          if (scan_cnt == CNT_W'(GAP_SCANS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = (BOUNCE_CYCLES < 1) ? 1 : $clog2(BOUNCE_CYCLES + 1);
  logic [BW-1:0] bounce_cnt;
  logic          bouncing;

  // Restarts on every state change so both make and break get a bounce window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               bounce_cnt <= '0;
    else if (state_d != state)             bounce_cnt <= '0;
    else if (bounce_cnt != BW'(BOUNCE_CYCLES)) bounce_cnt <= bounce_cnt + 1'b1;
  end

  assign bouncing = bounce_cnt < BW'(BOUNCE_CYCLES);

  always_comb begin
    pressed_eff = pressed;
    if (bouncing && state == PRESS) pressed_eff = bounce_cnt[0];
    if (bouncing && state == GAP)   pressed_eff = ~bounce_cnt[0];
  end
`else
  assign pressed_eff = pressed;
`endif

  // Passive switch: the held key shorts its column strobe onto its row line.
  always_comb begin
    row_out = ROWS_IDLE;
    if (pressed_eff && !col_in[code_q[COL_MSB:COL_LSB]])
      row_out[code_q[ROW_MSB:ROW_LSB]] = 1'b0;
  end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Models the physical side of the 4x4 key matrix: observes the column strobes driven by the keypad scanner and answers on the row lines as though one key is held down.
- Key presses arrive as 4-bit key codes over a valid/ready handshake. Each key is held for a programmable number of full column scans, then released for a programmable gap.
- Used as the stimulus end of the scanner interface, either on-board or in benches, replacing the mechanical keypad.

Parameters:
- HOLD_SCANS, 4: number of complete column scans a key stays pressed (>=1).
- GAP_SCANS, 2: number of complete column scans with all keys released after each press (>=1).
- CNT_W, 8: width of the scan counter; HOLD_SCANS and GAP_SCANS must each be < 2^CNT_W.
- BOUNCE_CYCLES, 8: clk cycles of contact bounce at press start. Only used when the optional feature is compiled in.

Ports:
- clk, in, 1: clock. col_in is synchronous to clk.
- rst, in, 1: asynchronous reset, active-high.
- key_valid, in, 1: key_code is valid.
- key_code, in, 4: bits [3:2] = row index, bits [1:0] = column index (code 4'b1101 = row 3, col 1).
- key_ready, out, 1: emulator can accept a key this cycle.
- col_in, in, 4: column strobes from the scanner, active-low.
- row_out, out, 4: row lines back to the scanner, active-low; idle 4'b1111.
- busy, out, 1: a press or gap is in progress.
- done, out, 1: one-cycle pulse when the gap after a press completes.

Behaviour:
- Reset (async, rst=1) forces the following immediately, including mid-press:
  - state=IDLE, scan_cnt=0, pressed=0;
  - key_ready=1, busy=0, done=0, row_out=4'b1111.
- row_out is combinational from col_in and registered state: row_out[r]=0 iff pressed=1, r==code_q[3:2] and col_in[code_q[1:0]]==0; all other bits are 1.
  - Same-cycle response to col_in, matching a passive switch matrix.
  - Multiple low columns: the row is low if the held key's column is among them.
- Scan event: col_prev is a register of col_in. scan_evt = (col_in==4'b0111) && (col_prev!=4'b0111). One event per full scan; a col_in that stays constant yields no further events.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: key_ready=1. On key_valid&&key_ready, latch code_q, set scan_cnt=0 and pressed=1, go to PRESS next cycle.
  - PRESS: key_ready=0, busy=1. On each scan_evt, scan_cnt++. On the scan_evt where scan_cnt==HOLD_SCANS-1, set pressed=0 and scan_cnt=0, go to GAP.
  - GAP: key_ready=0, busy=1, row_out=4'b1111. On the scan_evt where scan_cnt==GAP_SCANS-1, go to IDLE and assert done for exactly one cycle.
- Accept latency: pressed=1 is visible on row_out the cycle after the handshake.
- Back-to-back keys: key_ready is high in the cycle after done, so a new key can be accepted then. No key is buffered while busy; key_valid with key_ready=0 is ignored and the source must hold it.
- A scan_evt in the same cycle as an accept does not count toward the new press.
- scan_cnt saturates at 2^CNT_W-1 and never wraps, but it is always cleared before reaching that value under legal parameters.
- No scans arriving (scanner stopped): the emulator stays in PRESS/GAP indefinitely, with no timeout.

Optional Feature:
- Macro: KEYPAD_EMU_BOUNCE_EN.
- With it: for the first BOUNCE_CYCLES clk cycles after entering PRESS, the effective pressed value is bounce_cnt[0], so contact toggles every cycle, with bounce_cnt starting at 0. After that, pressed holds 1 steadily. Bounce cycles do not affect scan counting. The same bounce is applied for BOUNCE_CYCLES cycles after entering GAP, with effective pressed = ~bounce_cnt[0].
- Without it: clean make/break exactly as described in Behaviour; the bounce counter and BOUNCE_CYCLES are unused.

Decomposition:
- Shared package keypad_pkg:
  - FSM state enum (IDLE/PRESS/GAP);
  - column strobe constants COL0..COL3 = 4'b1110/1101/1011/0111 and ROWS_IDLE = 4'b1111;
  - key-code field positions (ROW_MSB=3, ROW_LSB=2, COL_MSB=1, COL_LSB=0).
- One sub-module: scan_event_detect (col_prev register plus scan_evt compare), reusable by scanner-side monitors.

Test Plan:
- Accept key_code=4'b0110 (row 1, col 2). With col_in cycling 1110, 1101, 1011, 0111, row_out=4'b1101 exactly while col_in=4'b1011, and 4'b1111 otherwise. Holds for 4 scan events (HOLD_SCANS=4), then row_out is 4'b1111 for 2 scans, then done pulses once and key_ready=1.
- Hold col_in=4'b1111 throughout a press: row_out stays 4'b1111 and no scan_evt occurs; busy stays 1.
- Key 4'b1101 held, col_in=4'b1001: row_out=4'b0111. Then col_in=4'b1011: row_out=4'b1111.
- Assert key_valid continuously with codes 0000 then 1111: the second is accepted on the cycle after done. key_ready=0 throughout PRESS/GAP, and the first key's row never appears during the second press.
- Assert rst mid-PRESS: row_out=4'b1111, key_ready=1, busy=0 in the same cycle, with no done pulse. Deassert rst and accept a fresh key normally.
- With KEYPAD_EMU_BOUNCE_EN and BOUNCE_CYCLES=8, key 4'b0000, col_in held at 4'b1110: row_out[0] alternates 1,0,1,0… for 8 cycles after accept, then stays 0.
